// File: rtl/odelay_ctrl_pkg.sv
// Shared types and helpers for the ODELAY tap-sequencing logic.
package odelay_ctrl_pkg;

    localparam int DEF_TAP_W = 9;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        VTC_OFF   = 3'd1,
        LOAD      = 3'd2,
        CHECK     = 3'd3,
        STEP      = 3'd4,
        STEP_WAIT = 3'd5,
        SETTLE    = 3'd6,
        DONE      = 3'd7
    } state_e;

    // Index width for n requesters; a single requester still gets one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/odelay_tap_sequencer_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the winner on advance_i.
module rr_arbiter
    import odelay_ctrl_pkg::*;
#(
    parameter int  NUM_REQ = 2,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o
);

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0] mask_s, masked_s, pick_s;

    // Requests at or above the pointer win first; otherwise wrap to the lowest index.
    always_comb begin
        mask_s = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            mask_s[j] = (j >= int'(ptr_q));
        end
        masked_s = req_i & mask_s;
        pick_s   = (masked_s != '0) ? masked_s : req_i;
        gnt_o    = pick_s & (~pick_s + NUM_REQ'(1));
        idx_o    = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            idx_o = idx_o | (gnt_o[j] ? ID_W'(j) : '0);
        end
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = (idx_o == ID_W'(NUM_REQ - 1)) ? '0 : idx_o + ID_W'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/odelay_tap_sequencer.sv
// Shares one ODELAY line between requesters: drops EN_VTC, moves the tap, settles, reports done.
module odelay_tap_sequencer
    import odelay_ctrl_pkg::*;
#(
    parameter int  NUM_REQ       = 2,
    parameter int  TAP_W         = DEF_TAP_W,
    parameter int  USE_LOAD      = 0,
    parameter int  VTC_WAIT      = 10,
    parameter int  SETTLE_CYCLES = 8,
    localparam int ID_W          = id_width(NUM_REQ)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*TAP_W-1:0] req_tap,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     done,
    output logic [ID_W-1:0]          done_id,
    output logic                     err,
    output logic                     busy,
    output logic                     dly_ce,
    output logic                     dly_inc,
    output logic                     dly_load,
    output logic [TAP_W-1:0]         dly_cntvaluein,
    output logic                     dly_en_vtc,
    input  logic [TAP_W-1:0]         dly_cntvalueout
);

    localparam int WAIT_MAX = (VTC_WAIT > SETTLE_CYCLES) ? VTC_WAIT : SETTLE_CYCLES;
    localparam int CNT_W    = $clog2(WAIT_MAX + 1);
    localparam logic [TAP_W:0] STEP_CAP = {1'b1, {TAP_W{1'b0}}};

    state_e               state_q, state_d;
    logic [TAP_W-1:0]     tgt_q, tgt_d, sel_tap_s;
    logic [ID_W-1:0]      id_q, id_d, gnt_idx_s, done_id_q, done_id_d;
    logic [NUM_REQ-1:0]   gnt_s;
    logic [CNT_W-1:0]     wcnt_q, wcnt_d;
    logic [TAP_W:0]       step_q, step_d;
    logic                 err_q, err_d, grant_s;
    logic                 ce_q, ce_d, inc_q, inc_d, load_q, load_d;
    logic                 vtc_q, vtc_d, done_q, done_d, busy_q, busy_d;

    assign grant_s = (state_q == IDLE) && (req_valid != '0);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .req_i     (req_valid),
        .advance_i (grant_s),
        .gnt_o     (gnt_s),
        .idx_o     (gnt_idx_s)
    );

    // Grant decode and selection of the winner's target tap.
    always_comb begin
        req_ready = grant_s ? gnt_s : '0;
        sel_tap_s = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            sel_tap_s = sel_tap_s | (gnt_s[j] ? req_tap[j*TAP_W +: TAP_W] : '0);
        end
    end

    // Next-state logic for the sequencer.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        id_d    = id_q;
        wcnt_d  = wcnt_q;
        step_d  = step_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (grant_s) begin
                    tgt_d  = sel_tap_s;
                    id_d   = gnt_idx_s;
                    err_d  = 1'b0;
                    step_d = '0;
                    if (sel_tap_s == dly_cntvalueout) begin
                        state_d = DONE;
                    end else begin
                        state_d = VTC_OFF;
                        wcnt_d  = CNT_W'(VTC_WAIT - 1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            VTC_OFF: begin
                if (wcnt_q == '0) begin
                    state_d = (USE_LOAD != 0) ? LOAD : STEP;
                end else begin
                    wcnt_d = wcnt_q - CNT_W'(1);
                end
            end
            LOAD: begin
                state_d = CHECK;
            end
            CHECK: begin
                err_d   = err_q | (dly_cntvalueout != tgt_q);
                state_d = SETTLE;
                wcnt_d  = CNT_W'(SETTLE_CYCLES - 1);
            end
            STEP: begin
                step_d  = step_q + (TAP_W + 1)'(1);
                state_d = STEP_WAIT;
            end
            STEP_WAIT: begin
                // A delay that never reaches the target is abandoned after a full tap range of steps.
                if (dly_cntvalueout == tgt_q) begin
                    state_d = SETTLE;
                    wcnt_d  = CNT_W'(SETTLE_CYCLES - 1);
                end else if (step_q == STEP_CAP) begin
                    err_d   = 1'b1;
                    state_d = SETTLE;
                    wcnt_d  = CNT_W'(SETTLE_CYCLES - 1);
                end else begin
                    state_d = STEP;
                end
            end
            SETTLE: begin
                if (wcnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    wcnt_d = wcnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the upcoming state so each pin is glitch-free.
    always_comb begin
        ce_d      = (state_d == STEP) || (state_d == LOAD);
        inc_d     = (state_d == STEP) && (tgt_d > dly_cntvalueout);
        load_d    = (state_d == LOAD);
        vtc_d     = (state_d == IDLE) || (state_d == DONE);
        done_d    = (state_d == DONE);
        done_id_d = done_d ? id_d : '0;
        busy_d    = (state_d != IDLE);
    end

    // State, transaction context and output registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            tgt_q     <= '0;
            id_q      <= '0;
            wcnt_q    <= '0;
            step_q    <= '0;
            err_q     <= 1'b0;
            ce_q      <= 1'b0;
            inc_q     <= 1'b0;
            load_q    <= 1'b0;
            vtc_q     <= 1'b1;
            done_q    <= 1'b0;
            done_id_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            id_q      <= id_d;
            wcnt_q    <= wcnt_d;
            step_q    <= step_d;
            err_q     <= err_d;
            ce_q      <= ce_d;
            inc_q     <= inc_d;
            load_q    <= load_d;
            vtc_q     <= vtc_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            busy_q    <= busy_d;
        end
    end

    assign dly_ce         = ce_q;
    assign dly_inc        = inc_q;
    assign dly_load       = load_q;
    assign dly_cntvaluein = tgt_q;
    assign dly_en_vtc     = vtc_q;
    assign done           = done_q;
    assign done_id        = done_id_q;
    assign err            = err_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_odelay_tap_sequencer.sv
// Bench for odelay_tap_sequencer: step-mode and load-mode instances driving behavioural delay lines.
module tb_odelay_tap_sequencer;

    localparam int TAP_W = 9;
    localparam int NR    = 2;
    localparam int VW    = 4;
    localparam int ST    = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   rr_ptr [2];
    bit   last_err [2];

    logic [NR-1:0]       a_valid, a_ready, b_valid, b_ready;
    logic [NR*TAP_W-1:0] a_tap, b_tap;
    logic                a_done, a_err, a_busy, a_ce, a_inc, a_load, a_vtc;
    logic                b_done, b_err, b_busy, b_ce, b_inc, b_load, b_vtc;
    logic [0:0]          a_done_id, b_done_id;
    logic [TAP_W-1:0]    a_cvin, a_cvout, b_cvin, b_cvout, a_set_val, b_set_val;
    logic                a_set, b_set, a_freeze, b_stuck;

    always #5 clk = ~clk;

    odelay_tap_sequencer #(.NUM_REQ(NR), .TAP_W(TAP_W), .USE_LOAD(0), .VTC_WAIT(VW), .SETTLE_CYCLES(ST)) u_a (
        .clk_in(clk), .rst_in(rst), .req_valid(a_valid), .req_tap(a_tap), .req_ready(a_ready),
        .done(a_done), .done_id(a_done_id), .err(a_err), .busy(a_busy), .dly_ce(a_ce), .dly_inc(a_inc),
        .dly_load(a_load), .dly_cntvaluein(a_cvin), .dly_en_vtc(a_vtc), .dly_cntvalueout(a_cvout)
    );

    odelay_tap_sequencer #(.NUM_REQ(NR), .TAP_W(TAP_W), .USE_LOAD(1), .VTC_WAIT(VW), .SETTLE_CYCLES(ST)) u_b (
        .clk_in(clk), .rst_in(rst), .req_valid(b_valid), .req_tap(b_tap), .req_ready(b_ready),
        .done(b_done), .done_id(b_done_id), .err(b_err), .busy(b_busy), .dly_ce(b_ce), .dly_inc(b_inc),
        .dly_load(b_load), .dly_cntvaluein(b_cvin), .dly_en_vtc(b_vtc), .dly_cntvalueout(b_cvout)
    );

    // Delay lines: tap moves on the CE edge; freeze/stuck model a line that ignores commands.
    always @(posedge clk) begin
        if (a_set) a_cvout <= a_set_val;
        else if (a_ce && !a_freeze) a_cvout <= a_load ? a_cvin : (a_inc ? a_cvout + 9'd1 : a_cvout - 9'd1);
        if (b_set) b_cvout <= b_set_val;
        else if (b_ce && !b_stuck) b_cvout <= b_load ? b_cvin : (b_inc ? b_cvout + 9'd1 : b_cvout - 9'd1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic grab(input bit use_b, output logic [1:0] rdy, output logic [6:0] vec,
                        output logic [0:0] did, output logic [TAP_W-1:0] cvin);
        if (use_b) begin
            rdy = b_ready; vec = {b_done, b_vtc, b_ce, b_inc, b_load, b_busy, b_err}; did = b_done_id; cvin = b_cvin;
        end else begin
            rdy = a_ready; vec = {a_done, a_vtc, a_ce, a_inc, a_load, a_busy, a_err}; did = a_done_id; cvin = a_cvin;
        end
    endtask

    // Reference arbitration: first valid requester at or after the pointer.
    function automatic int pick(input logic [1:0] vm, input int ptr);
        for (int k = 0; k < NR; k++) begin
            int j;
            j = (ptr + k) % NR;
            if (vm[j]) return j;
        end
        return 0;
    endfunction

    function automatic logic [TAP_W-1:0] near(input logic [TAP_W-1:0] cur);
        int t;
        t = int'(cur) + int'($urandom_range(0, 30)) - 15;
        if (t < 0) t = 0;
        if (t > 511) t = 511;
        return TAP_W'(t);
    endfunction

    // One transaction: predicts grant, per-cycle pin pattern, done cycle, err and final tap.
    task automatic txn(input bit use_b, input logic [1:0] vm, input logic [TAP_W-1:0] t0, input logic [TAP_W-1:0] t1);
        int id, n, d, bi;
        logic [TAP_W-1:0] s, tgt, cvin;
        bit eq, up, bad, ce_e;
        logic [1:0] rdy;
        logic [6:0] vec, exp;
        logic [0:0] did;
        string nm;
        bi = use_b ? 1 : 0;
        nm = use_b ? "B" : "A";
        @(negedge clk);
        if (use_b) begin b_valid = vm; b_tap = {t1, t0}; end
        else begin a_valid = vm; a_tap = {t1, t0}; end
        #1;
        id = pick(vm, rr_ptr[bi]);
        rr_ptr[bi] = (id + 1) % NR;
        s   = use_b ? b_cvout : a_cvout;
        tgt = (id == 1) ? t1 : t0;
        eq  = (s == tgt);
        up  = (tgt > s);
        bad = use_b ? b_stuck : a_freeze;
        n = eq ? 0 : (use_b ? 1 : (bad ? (1 << TAP_W) : (up ? int'(tgt) - int'(s) : int'(s) - int'(tgt))));
        d = eq ? 1 : (use_b ? VW + ST + 3 : VW + 2 * n + ST + 1);
        grab(use_b, rdy, vec, did, cvin);
        check({nm, " grant ready/done/busy/err"}, {27'd0, rdy, vec[6], vec[1], vec[0]},
              {27'd0, 2'(1 << id), 1'b0, 1'b0, last_err[bi]});
        for (int k = 1; k <= d; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (use_b) b_valid = '0; else a_valid = '0;
            end
            grab(use_b, rdy, vec, did, cvin);
            ce_e = !eq && (use_b ? (k == VW + 1) : (k > VW && k <= VW + 2 * n && ((k - VW) % 2 == 1)));
            exp  = {k == d, eq || k == d, ce_e, ce_e && !use_b && up, ce_e && use_b, 1'b1,
                    !eq && bad && (use_b ? (k >= VW + 3) : (k >= VW + 2 * n + 1))};
            check($sformatf("%s k=%0d done/vtc/ce/inc/load/busy/err", nm, k), {25'd0, vec}, {25'd0, exp});
            if (ce_e && use_b) check({nm, " cntvaluein"}, {23'd0, cvin}, {23'd0, tgt});
            if (k == d) check({nm, " done_id"}, {31'd0, did}, 32'(id));
        end
        last_err[bi] = !eq && bad;
        check({nm, " final tap"}, {23'd0, (use_b ? b_cvout : a_cvout)}, {23'd0, (bad ? s : tgt)});
    endtask

    initial begin
        logic [1:0] rdy;
        logic [6:0] vec;
        logic [0:0] did;
        logic [TAP_W-1:0] cvin;
        rst = 1'b1;
        a_valid = '0; b_valid = '0; a_tap = '0; b_tap = '0;
        a_set = 1'b1; b_set = 1'b1; a_set_val = 9'd10; b_set_val = 9'd0;
        a_freeze = 1'b0; b_stuck = 1'b0;
        rr_ptr[0] = 0; rr_ptr[1] = 0; last_err[0] = 1'b0; last_err[1] = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            grab(i == 1, rdy, vec, did, cvin);
            check($sformatf("reset pins inst%0d", i), {21'd0, rdy, vec, did, cvin[0]}, {21'd0, 2'b00, 7'b0100000, 1'b0, 1'b0});
            check($sformatf("reset cntvaluein inst%0d", i), {23'd0, cvin}, 32'd0);
        end
        a_set = 1'b0; b_set = 1'b0;
        rst = 1'b0;

        txn(1'b0, 2'b01, 9'd13, 9'd0);        // step up 10 -> 13
        txn(1'b0, 2'b10, 9'd0, 9'd5);         // step down 13 -> 5
        txn(1'b0, 2'b01, 9'd2, 9'd0);         // step down 5 -> 2
        txn(1'b1, 2'b01, 9'd300, 9'd0);       // load 0 -> 300
        txn(1'b1, 2'b01, 9'd300, 9'd0);       // already there
        b_stuck = 1'b1;
        txn(1'b1, 2'b10, 9'd0, 9'd100);       // load ignored -> err
        b_stuck = 1'b0;
        txn(1'b1, 2'b01, 9'd200, 9'd0);       // err still visible at grant, then cleared
        repeat (4) txn(1'b0, 2'b11, 9'd20, 9'd40);
        txn(1'b0, 2'b01, 9'd7, 9'd7);
        txn(1'b0, 2'b11, 9'd7, 9'd7);
        repeat (8) txn(1'b0, 2'($urandom_range(1, 3)), near(a_cvout), near(a_cvout));
        repeat (6) begin
            b_stuck = 1'($urandom_range(0, 1));
            txn(1'b1, 2'($urandom_range(1, 3)), 9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)));
        end
        b_stuck = 1'b0;
        a_freeze = 1'b1;
        txn(1'b0, 2'b01, a_cvout + 9'd3, 9'd0); // step cap exhausted
        a_freeze = 1'b0;
        txn(1'b0, 2'b01, 9'd0, 9'd0);

        // Reset during STEP_WAIT of a 0 -> 100 move by requester 0.
        @(negedge clk);
        a_valid = 2'b01; a_tap = {9'd0, 9'd100};
        #1;
        grab(1'b0, rdy, vec, did, cvin);
        check("A rst-move grant", {30'd0, rdy}, 32'd1);
        for (int k = 1; k <= VW + 4; k++) begin
            @(negedge clk);
            if (k == 1) a_valid = '0;
        end
        #2 rst = 1'b1;
        #1;
        grab(1'b0, rdy, vec, did, cvin);
        check("A mid-move reset pins", {22'd0, rdy, vec, did}, {22'd0, 2'b00, 7'b0100000, 1'b0});
        check("A mid-move reset cntvaluein", {23'd0, cvin}, 32'd0);
        check("A tap kept after reset", {23'd0, a_cvout}, 32'd2);
        rr_ptr[0] = 0; rr_ptr[1] = 0; last_err[0] = 1'b0; last_err[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            grab(1'b0, rdy, vec, did, cvin);
            check($sformatf("A quiet after reset %0d", k), {25'd0, vec}, {25'd0, 7'b0100000});
        end
        txn(1'b0, 2'b11, 9'd50, 9'd60);       // pointer back at requester 0

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
